// File: rtl/vc_pkg.sv
// Shared definitions for the two-VC output arbiter: VC encoding, default weights/depth,
// and the registered pop descriptor.
package vc_pkg;
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    localparam int DEF_VC0_WEIGHT = 3;
    localparam int DEF_VC1_WEIGHT = 1;
    localparam int DEF_DEST_DEPTH = 16;

    typedef struct packed {
        logic vld;
        logic vc;
    } pop_t;

    // Burst counter must hold the largest weight; never narrower than 2 bits.
    function automatic int burst_width(input int w0, input int w1);
        int m;
        m = (w0 > w1) ? w0 : w1;
        return ($clog2(m + 1) < 2) ? 2 : $clog2(m + 1);
    endfunction
endpackage

// File: rtl/vc_credit_counter.sv
// Downstream credit tracker: a pop consumes a credit, dest_pop returns one.
// A return while already full is flagged (sticky) and the count holds.
module vc_credit_counter
    import vc_pkg::*;
#(
    parameter int DEST_DEPTH = DEF_DEST_DEPTH,
    parameter int CW         = $clog2(DEST_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] credits,
    output logic          overflow
);
    localparam logic [CW-1:0] FULL = CW'(DEST_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits  <= FULL;
            overflow <= 1'b0;
        end else begin
            case ({take, give})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == FULL) overflow <= 1'b1;
                    else                 credits  <= credits + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/vc_arbiter.sv
// Two-VC weighted round-robin output arbiter with credit flow control and a 2-cycle
// pop-to-write pipeline. Define VC_ARB_STRICT_PRIO_EN for strict VC0 priority instead.
module vc_arbiter
    import vc_pkg::*;
#(
    parameter int data_width = 6,
    parameter int VC0_WEIGHT = DEF_VC0_WEIGHT,
    parameter int VC1_WEIGHT = DEF_VC1_WEIGHT,
    parameter int DEST_DEPTH = DEF_DEST_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic [data_width-1:0] data_in_vc0,
    input  logic [data_width-1:0] data_in_vc1,
    input  logic                  dest_pop,
    output logic                  rd_enable_vc0,
    output logic                  rd_enable_vc1,
    output logic                  wr_enable_out,
    output logic [data_width-1:0] data_out,
    output logic                  vc_id_out,
    output logic                  error_arb
);
    localparam int BW = burst_width(VC0_WEIGHT, VC1_WEIGHT);
    localparam int CW = $clog2(DEST_DEPTH + 1);

    logic          owner, owner_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic [CW-1:0] credits;
    logic          can_pop, pop, pop_vc;
    pop_t          pop_q;

    assign can_pop = (credits != '0) && reset;

`ifndef VC_ARB_STRICT_PRIO_EN
    logic          owner_ne, other_ne;
    logic [BW-1:0] owner_w;
    assign owner_ne = owner ? !empty_vc1 : !empty_vc0;
    assign other_ne = owner ? !empty_vc0 : !empty_vc1;
    assign owner_w  = owner ? BW'(VC1_WEIGHT) : BW'(VC0_WEIGHT);
`endif

    always_comb begin
        pop       = 1'b0;
        pop_vc    = VC0;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        if (can_pop) begin
`ifdef VC_ARB_STRICT_PRIO_EN
            if (!empty_vc0) begin
                pop    = 1'b1;
                pop_vc = VC0;
            end else if (!empty_vc1) begin
                pop    = 1'b1;
                pop_vc = VC1;
            end
`else
            if (owner_ne && burst_cnt < owner_w) begin
                pop       = 1'b1;
                pop_vc    = owner;
                burst_nxt = burst_cnt + BW'(1);
            end else if (other_ne) begin
                pop       = 1'b1;
                pop_vc    = !owner;
                owner_nxt = !owner;
                burst_nxt = BW'(1);
            end else if (owner_ne) begin
                // Other VC idle: let the owner continue with a fresh burst.
                pop       = 1'b1;
                pop_vc    = owner;
                burst_nxt = BW'(1);
            end
`endif
        end
    end

    assign rd_enable_vc0 = pop && (pop_vc == VC0);
    assign rd_enable_vc1 = pop && (pop_vc == VC1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= VC0;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // FIFO data arrives one cycle after the pop; register it with its source VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_q         <= '0;
            wr_enable_out <= 1'b0;
            data_out      <= '0;
            vc_id_out     <= 1'b0;
        end else begin
            pop_q         <= '{vld: pop, vc: pop_vc};
            wr_enable_out <= pop_q.vld;
            data_out      <= pop_q.vld ? (pop_q.vc ? data_in_vc1 : data_in_vc0) : '0;
            vc_id_out     <= pop_q.vld & pop_q.vc;
        end
    end

    vc_credit_counter #(
        .DEST_DEPTH (DEST_DEPTH),
        .CW         (CW)
    ) u_credit (
        .clk      (clk),
        .reset    (reset),
        .take     (pop),
        .give     (dest_pop),
        .credits  (credits),
        .overflow (error_arb)
    );
endmodule
